// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported dmem between the pipeline memory stage and one I/O agent.
// Define ARB_STATS_EN to add the saturating stall_cnt / io_cnt statistics outputs.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_en,
    input  logic              p_wren,
    input  logic [31:0]       p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    input  logic              io_req,
    input  logic              io_wren,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] debug_addr,
    output logic [DATA_W-1:0] debug_data
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       io_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] next_wait_cnt;
    logic              io_gnt;

    // Only the low word-address bits of the ALU result reach the dmem.
    logic unused_p_addr;
    assign unused_p_addr = ^p_addr[31:ADDR_W];

    assign io_ack     = (state == S_ACK);
    assign debug_addr = mem_addr;
    assign debug_data = mem_data;

    // Grant and port mux; the pipeline is only stalled when the I/O grant is forced.
    always_comb begin
        io_gnt   = 1'b0;
        p_stall  = 1'b0;
        mem_addr = p_addr[ADDR_W-1:0];
        mem_data = p_wdata;
        mem_wren = 1'b0;
        if (!reset) begin
            io_gnt  = io_req & ~io_ack & (~p_en | (wait_cnt == WAIT_LIMIT));
            p_stall = p_en & io_gnt;
            if (io_gnt) begin
                mem_addr = io_addr;
                mem_data = io_wdata;
                mem_wren = io_wren;
            end else begin
                mem_wren = p_en & p_wren;
            end
        end
    end

    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (io_gnt) begin
                    next_state    = S_ACK;
                    next_wait_cnt = '0;
                end else if (io_req && p_en) begin
                    next_state    = S_WAIT;
                    next_wait_cnt = WAIT_W'(1);
                end
            end
            S_WAIT: begin
                // A request withdrawn while waiting is abandoned without an ack.
                if (!io_req) begin
                    next_state    = S_IDLE;
                    next_wait_cnt = '0;
                end else if (io_gnt) begin
                    next_state    = S_ACK;
                    next_wait_cnt = '0;
                end else if (wait_cnt != WAIT_LIMIT) begin
                    next_wait_cnt = wait_cnt + 1'b1;
                end
            end
            S_ACK: begin
                next_state    = S_IDLE;
                next_wait_cnt = '0;
            end
            default: begin
                next_state    = S_IDLE;
                next_wait_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    // Read data is captured on the grant edge; a write echoes its own data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_rdata <= '0;
        end else if (io_gnt) begin
            io_rdata <= io_wren ? io_wdata : mem_q;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            io_cnt    <= '0;
        end else begin
            if (p_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (io_ack && (io_cnt != 16'hFFFF)) begin
                io_cnt <= io_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural dmem and an I/O read-data scoreboard.
// Also checks the statistics counters when ARB_STATS_EN is defined.
module tb_dmem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        p_en;
    logic        p_wren;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_stall;
    logic        io_req;
    logic        io_wren;
    logic [11:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_ack;
    logic [31:0] io_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [11:0] debug_addr;
    logic [31:0] debug_data;
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] io_cnt;
`endif

    logic [31:0] mem [0:4095];
    logic [31:0] exp_q[$];
    int          test_count = 0;
    int          fail_count = 0;
    int          exp_stalls = 0;
    int          exp_acks   = 0;
    int          blocked;
    bit          seen;

    dmem_port_arbiter #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .MAX_WAIT(4),
        .WAIT_W  (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .p_en      (p_en),
        .p_wren    (p_wren),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_stall   (p_stall),
        .io_req    (io_req),
        .io_wren   (io_wren),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_ack    (io_ack),
        .io_rdata  (io_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q),
        .debug_addr(debug_addr),
        .debug_data(debug_data)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .io_cnt    (io_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem writes on the falling edge; its read port is combinational.
    always @(negedge clock) begin
        if (mem_wren === 1'b1) mem[mem_addr] = mem_data;
    end
    assign mem_q = mem[mem_addr];

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ack(input string tag);
        logic [31:0] exp;
        check({tag, "_ack"}, 64'(io_ack), 64'd1);
        exp_acks++;
        test_count++;
        assert (exp_q.size() != 0) else begin
            fail_count++;
            $error("[TB] FAIL %s_sb: got empty scoreboard expected an entry", tag);
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check({tag, "_rdata"}, 64'(io_rdata), 64'(exp));
        end
    endtask

    task automatic apply_stimulus(input logic pe, input logic pw, input logic [31:0] pa,
                                  input logic [31:0] pd, input logic ir, input logic iw,
                                  input logic [11:0] ia, input logic [31:0] id);
        p_en     = pe;
        p_wren   = pw;
        p_addr   = pa;
        p_wdata  = pd;
        io_req   = ir;
        io_wren  = iw;
        io_addr  = ia;
        io_wdata = id;
    endtask

    task automatic check_output(input string tag, input logic stall, input logic wren,
                                input logic [11:0] addr);
        #1;
        check({tag, "_stall"}, 64'(p_stall), 64'(stall));
        check({tag, "_wren"}, 64'(mem_wren), 64'(wren));
        check({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        check({tag, "_dbg"}, 64'(debug_addr), 64'(addr));
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1, 1, 32'h30, 32'h5, 0, 0, 12'h0, 32'h0);
        #1;
        check("rst_stall", 64'(p_stall), 64'd0);
        check("rst_wren", 64'(mem_wren), 64'd0);
        check("rst_ack", 64'(io_ack), 64'd0);
        check("rst_rdata", 64'(io_rdata), 64'd0);
        tick();
        check("rst_ack2", 64'(io_ack), 64'd0);
        reset = 1'b0;
        apply_stimulus(0, 0, 32'h0, 32'h0, 0, 0, 12'h0, 32'h0);
        tick();

        // Preload dmem[0x010] through an unblocked I/O write.
        apply_stimulus(0, 0, 32'h0, 32'h0, 1, 1, 12'h010, 32'hCAFE0001);
        exp_q.push_back(32'hCAFE0001);
        check_output("pre", 0, 1, 12'h010);
        check("pre_data", 64'(mem_data), 64'hCAFE0001);
        tick();
        check_ack("pre");
        io_req = 0;
        tick();
        check("pre_idle", 64'(io_ack), 64'd0);

        // Test 1: unblocked I/O read acks in the next cycle.
        apply_stimulus(0, 0, 32'h0, 32'h0, 1, 0, 12'h010, 32'h0);
        exp_q.push_back(32'hCAFE0001);
        check_output("t1", 0, 0, 12'h010);
        tick();
        check_ack("t1");
        check("t1_stall", 64'(p_stall), 64'd0);
        io_req = 0;
        tick();

        // Test 2: pipeline busy; four blocked cycles, then a forced write grant.
        apply_stimulus(1, 0, 32'h100, 32'h0, 1, 1, 12'h020, 32'h1234);
        exp_q.push_back(32'h1234);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("t2_blk%0d", i), 0, 0, 12'h100);
            tick();
        end
        check_output("t2_gnt", 1, 1, 12'h020);
        check("t2_data", 64'(mem_data), 64'h1234);
        exp_stalls++;
        tick();
        check_ack("t2");
        check("t2_nostall", 64'(p_stall), 64'd0);
        check("t2_mem", 64'(mem[12'h020]), 64'h1234);
        io_req = 0;
        tick();

        // Test 3: colliding writes; I/O lands first, replayed pipeline store wins.
        apply_stimulus(1, 1, 32'h30, 32'hAAAA5555, 1, 1, 12'h030, 32'h11112222);
        exp_q.push_back(32'h11112222);
        for (int i = 0; i < 4; i++) tick();
        check_output("t3_gnt", 1, 1, 12'h030);
        check("t3_iodata", 64'(mem_data), 64'h11112222);
        exp_stalls++;
        tick();
        check_ack("t3");
        check_output("t3_replay", 0, 1, 12'h030);
        check("t3_pdata", 64'(mem_data), 64'hAAAA5555);
        io_req = 0;
        tick();
        check("t3_mem", 64'(mem[12'h030]), 64'hAAAA5555);
        apply_stimulus(0, 0, 32'h0, 32'h0, 0, 0, 12'h0, 32'h0);
        tick();

        // Test 4: io_req held through ack gives acks two cycles apart.
        apply_stimulus(0, 0, 32'h0, 32'h0, 1, 0, 12'h010, 32'h0);
        exp_q.push_back(32'hCAFE0001);
        exp_q.push_back(32'hCAFE0001);
        check_output("t4_g1", 0, 0, 12'h010);
        tick();
        check_ack("t4_a1");
        tick();
        check("t4_gap", 64'(io_ack), 64'd0);
        tick();
        check_ack("t4_a2");
        io_req = 0;
        tick();
        check("t4_end", 64'(io_ack), 64'd0);

        // Withdrawn request: no ack and no dmem write.
        apply_stimulus(1, 0, 32'h100, 32'h0, 1, 1, 12'h040, 32'hDEAD);
        tick();
        tick();
        io_req = 0;
        check_output("pv_drop", 0, 0, 12'h100);
        tick();
        check("pv_ack1", 64'(io_ack), 64'd0);
        tick();
        check("pv_ack2", 64'(io_ack), 64'd0);
        check("pv_mem", 64'(mem[12'h040] === 32'hDEAD), 64'd0);

        // Test 5: reset while waiting clears the counter.
        apply_stimulus(1, 0, 32'h100, 32'h0, 1, 0, 12'h010, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t5_rst_ack", 64'(io_ack), 64'd0);
        check("t5_rst_stall", 64'(p_stall), 64'd0);
        check("t5_rst_wren", 64'(mem_wren), 64'd0);
        tick();
        check("t5_rst_ack2", 64'(io_ack), 64'd0);
        reset = 1'b0;
        exp_q.push_back(32'hCAFE0001);
        blocked = 0;
        seen    = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (p_stall === 1'b1) seen = 1;
            else begin
                blocked++;
                tick();
            end
        end
        check("t5_grant_seen", 64'(seen), 64'd1);
        check("t5_blocked", 64'(blocked), 64'd4);
        if (seen) exp_stalls++;
        tick();
        check_ack("t5");
        io_req = 0;
        tick();

`ifdef ARB_STATS_EN
        check("stats_stall", 64'(stall_cnt), 64'(exp_stalls));
        check("stats_io", 64'(io_cnt), 64'(exp_acks));
`endif
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
